// File: rtl/cic_pkg.sv
// Shared types and helpers for the CIC interpolator feed sequencer.
package cic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } feed_state_e;

    // Saturating increment for counters up to 32 bits wide: returns cnt+1,
    // or cnt unchanged once it holds the all-ones value for 'width' bits.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int width);
        logic [31:0] max_val;
        if (width >= 32) begin
            max_val = '1;
        end else begin
            max_val = (32'd1 << width) - 32'd1;
        end
        return (cnt == max_val) ? cnt : cnt + 32'd1;
    endfunction

endpackage : cic_pkg

// File: rtl/cic_sat_counter.sv
// Saturating event counter with synchronous clear; clear has priority.
module cic_sat_counter
    import cic_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             in_clock,
    input  logic             in_reset_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    // Count events, stick at all ones, clear on request.
    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours; blocking here would create order races.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= WIDTH'(sat_inc(32'(r_cnt), WIDTH));
        end
    end

    assign o_cnt = r_cnt;

endmodule : cic_sat_counter

// File: rtl/cic_interp_feed_ctrl.sv
// Paces low-rate samples into the CIC interpolator on a sample tick,
// zero-fills underruns and flushes the filter with zeros on stop.
module cic_interp_feed_ctrl
    import cic_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FLUSH_LEN  = 3,
    parameter int CNT_WIDTH  = 16,
    parameter int ZERO_FILL  = 1
) (
    input  logic                  in_clock,
    input  logic                  in_reset_n,
    input  logic                  cmd_start,
    input  logic                  cmd_stop,
    input  logic                  tick,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy,
    output logic                  flushing,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  underrun_cnt,
    output logic [CNT_WIDTH-1:0]  late_cnt
);

    // Flush counter is wide enough to hold FLUSH_LEN itself (min 1 bit).
    localparam int FW = (FLUSH_LEN > 0) ? $clog2(FLUSH_LEN + 1) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_LEN);

    feed_state_e           r_state;
    feed_state_e           w_state_nxt;
    logic                  r_m_valid;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic [FW-1:0]         r_flush_cnt;
    logic                  r_done;

    logic                  w_slot_free;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic                  w_s_ready;
    logic                  w_underrun_inc;
    logic                  w_late_inc;
    logic                  w_cnt_clr;
    logic                  w_flush_adv;
    logic                  w_done;

    // The slot can take a new sample when empty or when it drains this cycle.
    assign w_slot_free = !r_m_valid || m_ready;

    // Next-state and per-cycle control decode.
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; a missing default would infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_load         = 1'b0;
        w_load_data    = '0;
        w_s_ready      = 1'b0;
        w_underrun_inc = 1'b0;
        w_late_inc     = 1'b0;
        w_cnt_clr      = 1'b0;
        w_flush_adv    = 1'b0;
        w_done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_start) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (tick) begin
                    if (!w_slot_free) begin
                        w_late_inc = 1'b1;
                    end else if (s_valid) begin
                        w_s_ready   = 1'b1;
                        w_load      = 1'b1;
                        w_load_data = s_data;
                    end else begin
                        w_underrun_inc = 1'b1;
                        w_load         = (ZERO_FILL != 0);
                    end
                end
                // A tick coinciding with stop still loads above.
                if (cmd_stop) begin
                    w_state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (tick) begin
                    if (!w_slot_free) begin
                        w_late_inc = 1'b1;
                    end else if (r_flush_cnt != FLUSH_LAST) begin
                        w_load      = 1'b1;
                        w_flush_adv = 1'b1;
                    end
                end
                // Finish only once the last zero has left the slot.
                if ((r_flush_cnt == FLUSH_LAST) && !r_m_valid) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output slot: load wins over drain, otherwise empty on handshake.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
        end else if (w_load) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_load_data;
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    // Flush zero counter: rearmed while running, advanced per injected zero.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_flush_cnt <= '0;
        end else if (r_state == RUN) begin
            r_flush_cnt <= '0;
        end else if (w_flush_adv) begin
            r_flush_cnt <= r_flush_cnt + FW'(1);
        end
    end

    // Registered one-cycle done pulse, aligned with the return to IDLE.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_done;
        end
    end

    cic_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_underrun_cnt (
        .in_clock   (in_clock),
        .in_reset_n (in_reset_n),
        .i_clr      (w_cnt_clr),
        .i_inc      (w_underrun_inc),
        .o_cnt      (underrun_cnt)
    );

    cic_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_late_cnt (
        .in_clock   (in_clock),
        .in_reset_n (in_reset_n),
        .i_clr      (w_cnt_clr),
        .i_inc      (w_late_inc),
        .o_cnt      (late_cnt)
    );

    assign s_ready  = w_s_ready;
    assign m_valid  = r_m_valid;
    assign m_data   = r_m_data;
    assign busy     = (r_state == RUN) || (r_state == FLUSH);
    assign flushing = (r_state == FLUSH);
    assign done     = r_done;

endmodule : cic_interp_feed_ctrl

// File: tb/tb_cic_interp_feed_ctrl.sv
// Directed bench for cic_interp_feed_ctrl. Three instances share stimulus:
// a = defaults, z = ZERO_FILL 0, c = CNT_WIDTH 4.
module tb_cic_interp_feed_ctrl;

    logic        in_clock = 1'b0;
    logic        in_reset_n;
    logic        cmd_start;
    logic        cmd_stop;
    logic        tick;
    logic        s_valid;
    logic        m_ready;
    logic [15:0] s_data;

    logic        a_s_ready, a_m_valid, a_busy, a_flushing, a_done;
    logic [15:0] a_m_data, a_underrun, a_late;
    logic        z_s_ready, z_m_valid, z_busy, z_flushing, z_done;
    logic [15:0] z_m_data, z_underrun, z_late;
    logic        c_s_ready, c_m_valid, c_busy, c_flushing, c_done;
    logic [15:0] c_m_data;
    logic [3:0]  c_underrun, c_late;

    int n_vec = 0;
    int n_err = 0;

    always #5 in_clock = ~in_clock;

    cic_interp_feed_ctrl u_dut_a (
        .in_clock(in_clock), .in_reset_n(in_reset_n), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .tick(tick), .s_valid(s_valid), .s_ready(a_s_ready), .s_data(s_data),
        .m_valid(a_m_valid), .m_ready(m_ready), .m_data(a_m_data), .busy(a_busy),
        .flushing(a_flushing), .done(a_done), .underrun_cnt(a_underrun), .late_cnt(a_late)
    );

    cic_interp_feed_ctrl #(.ZERO_FILL(0)) u_dut_z (
        .in_clock(in_clock), .in_reset_n(in_reset_n), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .tick(tick), .s_valid(s_valid), .s_ready(z_s_ready), .s_data(s_data),
        .m_valid(z_m_valid), .m_ready(m_ready), .m_data(z_m_data), .busy(z_busy),
        .flushing(z_flushing), .done(z_done), .underrun_cnt(z_underrun), .late_cnt(z_late)
    );

    cic_interp_feed_ctrl #(.CNT_WIDTH(4)) u_dut_c (
        .in_clock(in_clock), .in_reset_n(in_reset_n), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .tick(tick), .s_valid(s_valid), .s_ready(c_s_ready), .s_data(s_data),
        .m_valid(c_m_valid), .m_ready(m_ready), .m_data(c_m_data), .busy(c_busy),
        .flushing(c_flushing), .done(c_done), .underrun_cnt(c_underrun), .late_cnt(c_late)
    );

    // Advance to the next falling edge; inputs change and outputs are sampled there.
    task automatic step();
        @(negedge in_clock);
    endtask

    task automatic test_reset();
        in_reset_n = 1'b0;
        cmd_start = 1'b0; cmd_stop = 1'b0; tick = 1'b0;
        s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
        #3;
        n_vec++; if (a_m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid got %b want 0", a_m_valid); end
        n_vec++; if (a_m_data !== 16'h0) begin n_err++; $display("FAIL reset_m_data got %h want 0000", a_m_data); end
        n_vec++; if ({a_busy, a_flushing, a_done, a_s_ready} !== 4'b0) begin n_err++; $display("FAIL reset_flags got %b want 0000", {a_busy, a_flushing, a_done, a_s_ready}); end
        n_vec++; if ({a_underrun, a_late} !== 32'h0) begin n_err++; $display("FAIL reset_counters got %h want 0", {a_underrun, a_late}); end
        step();
        in_reset_n = 1'b1;
        step();
        n_vec++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL idle_after_reset busy got %b want 0", a_busy); end
    endtask

    // Three samples, one tick every 8 cycles, each appears one cycle after its tick.
    task automatic test_stream();
        m_ready = 1'b1; s_valid = 1'b1;
        cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
        n_vec++; if ({a_busy, a_flushing} !== 2'b10) begin n_err++; $display("FAIL start_run busy/flushing got %b want 10", {a_busy, a_flushing}); end
        for (int i = 1; i <= 3; i++) begin
            tick = 1'b1; s_data = 16'(i);
            #1;
            n_vec++; if (a_s_ready !== 1'b1) begin n_err++; $display("FAIL stream_s_ready[%0d] got %b want 1", i, a_s_ready); end
            step();
            tick = 1'b0;
            n_vec++; if (a_m_valid !== 1'b1 || a_m_data !== 16'(i)) begin n_err++; $display("FAIL stream_out[%0d] got v=%b d=%h want v=1 d=%h", i, a_m_valid, a_m_data, 16'(i)); end
            step();
            n_vec++; if (a_m_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain[%0d] m_valid got %b want 0", i, a_m_valid); end
            repeat (6) step();
        end
        n_vec++; if ({a_underrun, a_late} !== 32'h0) begin n_err++; $display("FAIL stream_counters got %h want 0", {a_underrun, a_late}); end
    endtask

    // Four empty ticks: zero-filled on a, skipped on z, counted on both.
    task automatic test_underrun();
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick = 1'b1;
            #1;
            n_vec++; if (a_s_ready !== 1'b0) begin n_err++; $display("FAIL underrun_s_ready[%0d] got %b want 0", i, a_s_ready); end
            step();
            tick = 1'b0;
            n_vec++; if (a_m_valid !== 1'b1 || a_m_data !== 16'h0) begin n_err++; $display("FAIL zero_fill[%0d] got v=%b d=%h want v=1 d=0000", i, a_m_valid, a_m_data); end
            n_vec++; if (z_m_valid !== 1'b0) begin n_err++; $display("FAIL no_fill[%0d] m_valid got %b want 0", i, z_m_valid); end
            repeat (7) step();
        end
        n_vec++; if (a_underrun !== 16'd4) begin n_err++; $display("FAIL underrun_cnt_zf1 got %0d want 4", a_underrun); end
        n_vec++; if (z_underrun !== 16'd4) begin n_err++; $display("FAIL underrun_cnt_zf0 got %0d want 4", z_underrun); end
        n_vec++; if (a_late !== 16'd0) begin n_err++; $display("FAIL underrun_late got %0d want 0", a_late); end
    endtask

    // m_ready low for 20 cycles spanning ticks at 0, 8, 16.
    task automatic test_backpressure();
        s_valid = 1'b1; m_ready = 1'b0; s_data = 16'h1234;
        tick = 1'b1;
        #1;
        n_vec++; if (a_s_ready !== 1'b1) begin n_err++; $display("FAIL bp_first_s_ready got %b want 1", a_s_ready); end
        step();
        tick = 1'b0; s_data = 16'h5555;
        for (int c = 1; c < 20; c++) begin
            n_vec++; if (a_m_valid !== 1'b1 || a_m_data !== 16'h1234) begin n_err++; $display("FAIL bp_hold[%0d] got v=%b d=%h want v=1 d=1234", c, a_m_valid, a_m_data); end
            if (c % 8 == 0) begin
                tick = 1'b1;
                #1;
                n_vec++; if (a_s_ready !== 1'b0) begin n_err++; $display("FAIL bp_late_s_ready[%0d] got %b want 0", c, a_s_ready); end
            end
            step();
            tick = 1'b0;
        end
        n_vec++; if (a_m_valid !== 1'b1 || a_m_data !== 16'h1234) begin n_err++; $display("FAIL bp_hold_end got v=%b d=%h want v=1 d=1234", a_m_valid, a_m_data); end
        m_ready = 1'b1;
        step();
        n_vec++; if (a_m_valid !== 1'b0) begin n_err++; $display("FAIL bp_release m_valid got %b want 0", a_m_valid); end
        n_vec++; if (a_late !== 16'd2) begin n_err++; $display("FAIL bp_late_cnt got %0d want 2", a_late); end
        n_vec++; if (a_underrun !== 16'd4) begin n_err++; $display("FAIL bp_underrun_cnt got %0d want 4", a_underrun); end
    endtask

    // Stop with a sample pending: sample, then 3 zeros, then a single done.
    task automatic test_stop_flush();
        logic [15:0] got [8];
        logic [15:0] want [4];
        int n_got;
        int n_done;
        want[0] = 16'hBEEF; want[1] = 16'h0; want[2] = 16'h0; want[3] = 16'h0;
        n_got = 0; n_done = 0;
        m_ready = 1'b0; s_valid = 1'b1; s_data = 16'hBEEF;
        tick = 1'b1;
        step();
        tick = 1'b0;
        cmd_stop = 1'b1;
        step();
        cmd_stop = 1'b0;
        n_vec++; if ({a_busy, a_flushing} !== 2'b11) begin n_err++; $display("FAIL flush_enter busy/flushing got %b want 11", {a_busy, a_flushing}); end
        n_vec++; if (a_m_valid !== 1'b1 || a_m_data !== 16'hBEEF) begin n_err++; $display("FAIL flush_pending got v=%b d=%h want v=1 d=beef", a_m_valid, a_m_data); end
        cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
        n_vec++; if (a_flushing !== 1'b1) begin n_err++; $display("FAIL flush_ignores_start flushing got %b want 1", a_flushing); end
        n_vec++; if (a_late !== 16'd2) begin n_err++; $display("FAIL flush_start_no_clear late got %0d want 2", a_late); end
        m_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick = (i % 4 == 1);
            if (a_m_valid && m_ready && n_got < 8) begin
                got[n_got] = a_m_data;
                n_got++;
            end
            if (a_done) n_done++;
            step();
            tick = 1'b0;
        end
        n_vec++; if (n_got !== 4) begin n_err++; $display("FAIL flush_transfers got %0d want 4", n_got); end
        for (int k = 0; k < 4; k++) begin
            n_vec++; if (got[k] !== want[k]) begin n_err++; $display("FAIL flush_data[%0d] got %h want %h", k, got[k], want[k]); end
        end
        n_vec++; if (n_done !== 1) begin n_err++; $display("FAIL flush_done_pulses got %0d want 1", n_done); end
        n_vec++; if ({a_busy, a_flushing, a_m_valid} !== 3'b000) begin n_err++; $display("FAIL flush_idle busy/flushing/m_valid got %b want 000", {a_busy, a_flushing, a_m_valid}); end
        n_vec++; if (a_late !== 16'd2) begin n_err++; $display("FAIL flush_late_cnt got %0d want 2", a_late); end
    endtask

    // 20 empty ticks: 4-bit counter holds at 15; a new start clears it.
    task automatic test_saturate();
        bit idle_seen;
        m_ready = 1'b1; s_valid = 1'b0;
        cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
        n_vec++; if (c_underrun !== 4'd0) begin n_err++; $display("FAIL sat_start_clear got %0d want 0", c_underrun); end
        repeat (20) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
        n_vec++; if (c_underrun !== 4'd15) begin n_err++; $display("FAIL sat_hold got %0d want 15", c_underrun); end
        n_vec++; if (a_underrun !== 16'd20) begin n_err++; $display("FAIL sat_wide_cnt got %0d want 20", a_underrun); end
        n_vec++; if (c_late !== 4'd0) begin n_err++; $display("FAIL sat_late got %0d want 0", c_late); end
        cmd_stop = 1'b1;
        step();
        cmd_stop = 1'b0;
        idle_seen = 1'b0;
        for (int i = 0; i < 100 && !idle_seen; i++) begin
            tick = (i % 2 == 0);
            step();
            tick = 1'b0;
            if (!a_busy && !c_busy) idle_seen = 1'b1;
        end
        n_vec++; if (idle_seen !== 1'b1) begin n_err++; $display("FAIL sat_flush_timeout idle got %b want 1", idle_seen); end
        step();
        cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
        n_vec++; if (c_underrun !== 4'd0) begin n_err++; $display("FAIL sat_restart_clear got %0d want 0", c_underrun); end
        n_vec++; if (a_underrun !== 16'd0) begin n_err++; $display("FAIL sat_restart_clear_wide got %0d want 0", a_underrun); end
    endtask

    // Reset asserted between edges during FLUSH drops outputs immediately.
    task automatic test_async_reset();
        int n_done;
        n_done = 0;
        m_ready = 1'b0; s_valid = 1'b1; s_data = 16'h0A0A;
        tick = 1'b1;
        step();
        tick = 1'b0;
        cmd_stop = 1'b1;
        step();
        cmd_stop = 1'b0;
        n_vec++; if ({a_flushing, a_m_valid} !== 2'b11) begin n_err++; $display("FAIL rst_pre flushing/m_valid got %b want 11", {a_flushing, a_m_valid}); end
        #2;
        in_reset_n = 1'b0;
        #1;
        n_vec++; if ({a_m_valid, a_busy, a_flushing} !== 3'b000) begin n_err++; $display("FAIL rst_async m_valid/busy/flushing got %b want 000", {a_m_valid, a_busy, a_flushing}); end
        step();
        in_reset_n = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick = (i % 3 == 0);
            step();
            tick = 1'b0;
            if (a_done) n_done++;
            n_vec++; if ({a_busy, a_m_valid} !== 2'b00) begin n_err++; $display("FAIL rst_idle[%0d] busy/m_valid got %b want 00", i, {a_busy, a_m_valid}); end
        end
        n_vec++; if (n_done !== 0) begin n_err++; $display("FAIL rst_no_done pulses got %0d want 0", n_done); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_underrun();
        test_backpressure();
        test_stop_flush();
        test_saturate();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_cic_interp_feed_ctrl

// File: doc/cic_interp_feed_ctrl.md
Name: cic_interp_feed_ctrl

Overview:
Sequencer in front of the cic_interpolator input port. Paces low-rate samples into the interpolator on a sample-rate tick and zero-fills upstream underruns so the high-rate output never stalls. On stop, it flushes the filter with zeros before returning to idle. Exposes status flags and saturating underrun/late counters for the control plane.

Parameters:
DATA_WIDTH, 16, sample width; matches interpolator IN_WIDTH.
FLUSH_LEN, 3, zero samples injected on stop; set to at least interpolator STAGES.
CNT_WIDTH, 16, width of the underrun and late counters.
ZERO_FILL, 1, 1 = inject zero on an underrun tick; 0 = skip the slot.

Ports:
in_clock  in  1  clock
in_reset_n  in  1  reset, asynchronous, active-low
cmd_start  in  1  single-cycle start request
cmd_stop  in  1  single-cycle stop request
tick  in  1  low-rate sample strobe, one cycle wide
s_valid  in  1  upstream sample valid
s_ready  out  1  upstream accept; asserted only in load cycles
s_data  in  DATA_WIDTH  upstream signed sample
m_valid  out  1  sample valid to the interpolator in_valid
m_ready  in  1  interpolator in_ready
m_data  out  DATA_WIDTH  signed sample to the interpolator in_data
busy  out  1  high in RUN or FLUSH
flushing  out  1  high in FLUSH
done  out  1  one-cycle pulse when FLUSH completes
underrun_cnt  out  CNT_WIDTH  ticks with no upstream sample, saturating
late_cnt  out  CNT_WIDTH  ticks lost because the slot was still occupied, saturating

Behaviour:
- Reset: in_reset_n is asynchronous and active-low; clock is in_clock. All outputs reset to 0, state resets to IDLE, flush counter resets to 0.
- Output slot: a single register holding m_valid and m_data.
  - m_valid stays high and m_data stays stable until m_ready=1; the slot empties on that cycle.
  - Transfer to the interpolator: m_valid and m_ready both high.
- Slot free: the slot is free if m_valid=0, or if m_valid and m_ready are both high in the same cycle. A free slot can be reloaded in that same cycle.
- State IDLE:
  - s_ready=0, m_valid=0.
  - cmd_start clears both counters and moves to RUN on the next cycle.
  - cmd_stop is ignored.
  - If cmd_start and cmd_stop arrive together, start wins.
- State RUN, on tick:
  - Slot free and s_valid=1: s_ready=1 combinationally in the tick cycle; load s_data; m_valid=1 the next cycle (latency 1).
  - Slot free and s_valid=0:
    - underrun_cnt+1.
    - If ZERO_FILL=1, load 0 with m_valid=1.
    - If ZERO_FILL=0, the slot stays empty.
  - Slot occupied: late_cnt+1; s_ready=0; no load.
  - Outside tick cycles, s_ready=0.
- Stop from RUN:
  - cmd_stop moves to FLUSH on the next cycle. An already loaded sample is kept and delivered.
  - cmd_start in RUN is ignored.
  - If cmd_stop coincides with a tick, that tick's load still happens.
- State FLUSH:
  - s_ready=0.
  - Each tick with a free slot loads a zero and increments the flush counter.
  - A tick with the slot occupied increments late_cnt and does not advance the flush counter.
  - After FLUSH_LEN zeros have been loaded and the last one has transferred (m_valid low), pulse done for one cycle and return to IDLE.
  - cmd_start and cmd_stop are ignored in FLUSH.
  - FLUSH_LEN=0: done pulses the cycle after entering FLUSH.
- Counters: saturate at all ones and do not wrap.
- tick while IDLE: no effect.
- Reset mid-operation: the pending slot is discarded immediately with m_valid=0. No done pulse is produced.

Decomposition:
- cic_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, FLUSH} feed_state_e.
  - Helper function sat_inc(cnt) that returns saturating +1.
- One natural sub-module, cic_sat_counter, parameterised by width, with clear/inc inputs. Instantiated twice, for the underrun and late counters.
- The output slot and FSM stay in the top level.

Test Plan:
1. Start, tick every 8 cycles, s_valid always high with values 1,2,3, m_ready=1 → m_data 1,2,3, one per tick, each one cycle after its tick; underrun_cnt=0, late_cnt=0.
2. RUN with s_valid=0 for 4 ticks, ZERO_FILL=1 → four m_data=0 transfers, underrun_cnt=4. With ZERO_FILL=0 → no m_valid, underrun_cnt=4.
3. m_ready held low for 20 cycles across 3 ticks (period 8) → first sample held stable, late_cnt=2; s_ready never high on the late ticks.
4. Stop in RUN with one sample pending, FLUSH_LEN=3 → pending sample delivered, then 3 zeros, done pulse once, busy drops; cmd_start pulsed during FLUSH has no effect.
5. Force underrun_cnt to saturate using CNT_WIDTH=4 and 20 empty ticks → holds at 15; next cmd_start clears it to 0.
6. Assert in_reset_n low mid-FLUSH, between clock edges → m_valid, busy and flushing drop asynchronously; after release the state is IDLE and done never pulses.
